// File: rtl/bitslam_pkg.sv
// bitslam_pkg: register map, LFSR tap positions and output sizing shared by the bitslam blocks
package bitslam_pkg;
   localparam logic [1:0] REG_DIV = 2'd0;
   localparam logic [1:0] REG_TAP = 2'd1;
   localparam logic [1:0] REG_VOL = 2'd2;
   localparam logic [1:0] REG_LEN = 2'd3;
   localparam int REGS_PER_VOICE = 4;
   localparam int TAP_POS [4] = '{1, 4, 6, 9};
   localparam int LFSR_SEED = 1;
   function automatic int out_width(input int vol_w, input int voices);
      return vol_w + $clog2(voices);
   endfunction
endpackage

// File: rtl/bitslam_voice.sv
// bitslam_voice: one LFSR voice with clock divider, tap mask, volume and one-shot length gate
module bitslam_voice
   import bitslam_pkg::*;
#(
   parameter int LFSR_WIDTH = 10,
   parameter int VOL_WIDTH  = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic [1:0]           offset,
   input  logic [5:0]           data,
   input  logic                 frame,
   output logic [VOL_WIDTH-1:0] sample,
   output logic                 active
);
   logic [5:0]            div, cnt, len;
   logic [3:0]            mask;
   logic [VOL_WIDTH-1:0]  vol;
   logic [LFSR_WIDTH-1:0] lfsr;
   logic                  fb, tick, len_we;
   always_comb begin
      fb = 1'b0;
      for (int i = 0; i < 4; i++) fb ^= mask[i] & |((lfsr >> TAP_POS[i]) & LFSR_WIDTH'(1));
   end
   assign tick   = cnt >= div;
   assign len_we = we && offset == REG_LEN;
   assign sample = (lfsr[0] && active) ? vol : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div    <= '0;
         cnt    <= '0;
         len    <= '0;
         mask   <= '0;
         vol    <= '0;
         lfsr   <= LFSR_WIDTH'(LFSR_SEED);
         active <= 1'b1;
      end else begin
         cnt <= tick ? '0 : cnt + 6'd1;
         // an all-zero LFSR is a dead state, so it reseeds instead of shifting
         if (tick) lfsr <= (lfsr == '0) ? LFSR_WIDTH'(LFSR_SEED) : {lfsr[LFSR_WIDTH-2:0], fb};
         if (we && offset == REG_DIV) div <= data;
         if (we && offset == REG_TAP) mask <= data[3:0];
         if (we && offset == REG_VOL) vol <= data[VOL_WIDTH-1:0];
         if (len_we) begin
            len    <= data;
            active <= 1'b1;
         end else if (frame && len != '0) begin
            len <= len - 6'd1;
            if (len == 6'd1) active <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/bitslam_multi.sv
// bitslam_multi: multi-voice LFSR synth with pin-style address/data write port and summing mixer
module bitslam_multi
   import bitslam_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int LFSR_WIDTH = 10,
   parameter int VOL_WIDTH  = 3,
   parameter int FRAME_DIV  = 256,
   parameter int AUTO_INC   = 1
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         sel,
   input  logic [5:0]                                   bus,
   output logic [out_width(VOL_WIDTH, NUM_VOICES)-1:0] audio_out,
   output logic [NUM_VOICES-1:0]                        voice_active
);
   localparam int OW = out_width(VOL_WIDTH, NUM_VOICES);
   localparam int PW = $clog2(FRAME_DIV);
   localparam logic [5:0] LAST = 6'(REGS_PER_VOICE * NUM_VOICES - 1);
   logic [5:0]           addr;
   logic [PW-1:0]        pre;
   logic                 frame;
   logic [OW-1:0]        sum;
   logic [VOL_WIDTH-1:0] sample [NUM_VOICES];
   assign frame = pre == PW'(FRAME_DIV - 1);
   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_VOICES; i++) sum += OW'(sample[i]);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr      <= '0;
         pre       <= '0;
         audio_out <= '0;
      end else begin
         pre       <= frame ? '0 : pre + PW'(1);
         audio_out <= sum;
         // unmapped addresses also wrap to 0 so a stray write cannot strand the pointer
         if (!sel) addr <= bus;
         else if (AUTO_INC != 0) addr <= (addr >= LAST) ? '0 : addr + 6'd1;
      end
   end
   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_v
      bitslam_voice #(
         .LFSR_WIDTH(LFSR_WIDTH),
         .VOL_WIDTH (VOL_WIDTH)
      ) u_voice (
         .clk   (clk),
         .rst_n (rst_n),
         .we    (sel && addr[5:2] == 4'(g)),
         .offset(addr[1:0]),
         .data  (bus),
         .frame (frame),
         .sample(sample[g]),
         .active(voice_active[g])
      );
   end
endmodule

// File: tb/tb_bitslam_multi.sv
// tb_bitslam_multi: directed and random stimulus checked against a behavioural model of the synth
module tb_bitslam_multi;
   localparam int NV = 4;
   localparam int FD = 256;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sel = 1'b0;
   logic [5:0] bus = '0;
   logic [4:0] audio_out;
   logic [3:0] voice_active;
   int checks = 0;
   int failures = 0;
   int m_addr, m_pre, m_audio;
   int m_div [NV], m_mask [NV], m_vol [NV], m_len [NV], m_act [NV], m_lfsr [NV], m_cnt [NV];
   int taps [4] = '{1, 4, 6, 9};

   always #5 clk = ~clk;

   bitslam_multi dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sel         (sel),
      .bus         (bus),
      .audio_out   (audio_out),
      .voice_active(voice_active)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int lfsr_next(input int s, input int msk);
      int fb = 0;
      if (s == 0) return 1;
      for (int i = 0; i < 4; i++) if ((msk >> i) & 1) fb ^= (s >> taps[i]) & 1;
      return ((s << 1) & 1023) | fb;
   endfunction

   function automatic int act_vec();
      int a = 0;
      for (int v = 0; v < NV; v++) a |= m_act[v] << v;
      return a;
   endfunction

   task automatic model_reset();
      m_addr = 0; m_pre = 0; m_audio = 0;
      for (int v = 0; v < NV; v++) begin
         m_div[v] = 0; m_mask[v] = 0; m_vol[v] = 0; m_len[v] = 0;
         m_act[v] = 1; m_lfsr[v] = 1; m_cnt[v] = 0;
      end
   endtask

   // one clock: drive the write port, advance the model, then compare outputs
   task automatic step(input bit s, input int b);
      bit fr;
      sel = s;
      bus = 6'(b);
      m_audio = 0;
      for (int v = 0; v < NV; v++) if ((m_lfsr[v] & 1) && m_act[v]) m_audio += m_vol[v];
      fr = (m_pre == FD - 1);
      m_pre = (m_pre + 1) % FD;
      for (int v = 0; v < NV; v++) begin
         if (m_cnt[v] >= m_div[v]) begin
            m_cnt[v] = 0;
            m_lfsr[v] = lfsr_next(m_lfsr[v], m_mask[v]);
         end else m_cnt[v]++;
         if (s && m_addr == 4 * v + 3) begin
            m_len[v] = b; m_act[v] = 1;
         end else if (fr && m_len[v] > 0) begin
            m_len[v]--; m_act[v] = (m_len[v] != 0);
         end
      end
      if (s) begin
         if (m_addr < 4 * NV) begin
            if (m_addr % 4 == 0) m_div[m_addr / 4] = b;
            if (m_addr % 4 == 1) m_mask[m_addr / 4] = b & 15;
            if (m_addr % 4 == 2) m_vol[m_addr / 4] = b & 7;
         end
         m_addr = (m_addr >= 4 * NV - 1) ? 0 : m_addr + 1;
      end else m_addr = b;
      @(posedge clk);
      #1;
      chk("audio_out", audio_out, m_audio);
      chk("voice_active", voice_active, act_vec());
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, m_addr);
   endtask

   task automatic chk_lfsrs(input string tag);
      chk({tag, "_lfsr0"}, dut.g_v[0].u_voice.lfsr, m_lfsr[0]);
      chk({tag, "_lfsr1"}, dut.g_v[1].u_voice.lfsr, m_lfsr[1]);
      chk({tag, "_lfsr2"}, dut.g_v[2].u_voice.lfsr, m_lfsr[2]);
      chk({tag, "_lfsr3"}, dut.g_v[3].u_voice.lfsr, m_lfsr[3]);
   endtask

   initial begin
      int k, seen0, seen7, seen28;
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_audio", audio_out, 0);
      chk("rst_active", voice_active, 4'hF);
      chk_lfsrs("rst");
      rst_n = 1'b1;
      idle(100);
      chk_lfsrs("idle");

      step(0, 0); step(1, 0); step(1, 9); step(1, 7); step(1, 0);
      seen0 = 0; seen7 = 0;
      repeat (1100) begin
         step(0, m_addr);
         if (audio_out == 0) seen0++;
         if (audio_out == 7) seen7++;
      end
      chk("v0_toggle0", seen0 > 0, 1);
      chk("v0_toggle7", seen7 > 0, 1);
      chk("v0_seq", dut.g_v[0].u_voice.lfsr, m_lfsr[0]);

      step(0, 0);
      repeat (2) begin step(1, 0); step(1, 0); step(1, 7); step(1, 0); end
      idle(40);

      step(0, 9); step(1, 9); step(1, 7); step(1, 3);
      k = 0;
      while (voice_active[2] && k < 4 * FD) begin idle(1); k++; end
      chk("len3_expired", voice_active[2], 0);
      do step(0, 11); while (m_pre != FD - 1);
      step(1, 2);
      chk("len_reload", dut.g_v[2].u_voice.len, 2);
      idle(2 * FD + 4);

      step(0, 16); step(1, 63);
      chk("unmapped_wrap", dut.addr, 0);
      chk("unmapped_div0", dut.g_v[0].u_voice.div, m_div[0]);
      chk("unmapped_len3", dut.g_v[3].u_voice.len, m_len[3]);
      step(1, 0);

      repeat (600) step(1'($urandom_range(0, 1)), $urandom_range(0, 63));

      step(0, 0); step(1, 0); step(1, 9); step(1, 7); step(1, 0);
      k = 0;
      while (m_audio == 0 && k < 50) begin step(0, 4); k++; end
      chk("pre_reset_nonzero", audio_out != 0, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_audio", audio_out, 0);
      chk("async_active", voice_active, 4'hF);
      model_reset();
      chk_lfsrs("async");
      sel = 1'b0; bus = '0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      step(0, 2); step(1, 7); step(0, 6); step(1, 7);
      step(0, 10); step(1, 7); step(0, 14); step(1, 7);
      seen28 = 0;
      repeat (30) begin
         step(0, 14);
         if (audio_out == 28) seen28++;
      end
      chk("sum28", seen28 > 0, 1);
      chk_lfsrs("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
